regfile_test_ctrl: RTL and testbench
====================================

// Module: regfile_test_ctrl
// PURPOSE
//   Button-driven sequencer for the register-file test design. Takes debounced
//   button levels and sequences the register file's one read and one write port:
//   select a register, load it from the switches, increment it, or clear all.
//   Also drives the display from the selected register. Sits between the button
//   debouncers and the register file; it is the only writer of the file.
// PARAMETERS
//   ADDR_WIDTH  3  register index width; the file has 2**ADDR_WIDTH entries
//   DATA_WIDTH  8  register data width
// PORTS
//   clk        in   1    system clock; all state updates on posedge
//   rst        in   1    asynchronous, active-high reset
//   btn        in   4    debounced levels: [0] next, [1] write, [2] inc, [3] clear
//   sw         in   DW   switch value, used as write data
//   rf_raddr   out  AW   register file read address
//   rf_rdata   in   DW   register file read data, valid 1 clk after rf_raddr (sync read)
//   rf_we      out  1    register file write enable, registered
//   rf_waddr   out  AW   register file write address, registered
//   rf_wdata   out  DW   register file write data, registered
//   sel_addr   out  AW   currently selected register index
//   disp_data  out  DW   registered copy of rf_rdata for the display
//   busy       out  1    1 when state != IDLE
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE; sel_addr, rf_we, rf_waddr, rf_wdata and
//     disp_data = 0; clr_cnt = 0; btn_q = 4'b1111.
//   btn_q is set to all-ones so a button held through reset does not fire.
//   Edge detect: edge = btn & ~btn_q; btn_q <= btn every clk, in every state.
//   Edges seen while busy=1 are dropped and never queued.
//   Simultaneous edges in IDLE: priority clear > write > inc > next.
//     Only the highest-priority edge acts; the rest are dropped.
//   rf_raddr = sel_addr in every state except CLR, where it is don't-care.
//   States:
//   - IDLE: disp_data <= rf_rdata each clk; rf_we <= 0.
//     - next edge: sel_addr <= sel_addr+1, wrapping 2**AW-1 -> 0; stay IDLE.
//     - write edge: rf_waddr <= sel_addr; rf_wdata <= sw, sampled this clk;
//       rf_we <= 1; go to WR.
//     - inc edge: go to RD.
//     - clear edge: clr_cnt <= 0; go to CLR.
//   - WR: rf_we <= 0; go to IDLE. rf_we is high for exactly 1 clk.
//   - RD: rf_wdata <= rf_rdata + 1, truncated to DW so all-ones wraps to 0;
//     rf_waddr <= sel_addr; rf_we <= 1; go to WB.
//   - WB: rf_we <= 0; go to IDLE. Latency from inc edge to write is 2 clk.
//   - CLR: rf_we <= 1; rf_waddr <= clr_cnt; rf_wdata <= 0; clr_cnt <= clr_cnt+1.
//     After clr_cnt reaches 2**AW-1, the next clk sets rf_we <= 0 and
//     sel_addr <= 0, then goes to IDLE. Exactly 2**AW write pulses, addresses
//     ascending from 0.
//   disp_data reflects a completed write no later than 2 clk after rf_we falls.
//   rst mid-operation (e.g. in CLR) aborts at once: rf_we drops with rst and no
//     further writes occur. A partly cleared file is accepted.
//   sel_addr does not change in WR, RD or WB.
// TESTING
//   1. Hold btn=4'b0100 through reset, release rst, keep btn -> no write and no
//      sel_addr change. Release, then press again -> one inc sequence.
//   2. Press next 9x with AW=3 -> sel_addr steps 1..7, 0, 1. rf_we never asserted.
//   3. sel_addr=2, sw=8'hA5, write edge -> next clk rf_we=1, rf_waddr=2,
//      rf_wdata=A5 for 1 clk. disp_data=A5 within 2 clk of rf_we falling.
//   4. Reg 2 holds 8'hFF, inc edge -> RD then WB; rf_wdata=8'h00 with rf_we at
//      edge+2. Reg 2 holding 8'h41 -> 8'h42.
//   5. Clear edge -> 8 consecutive rf_we pulses, waddr 0..7, wdata 0. busy=1 for
//      9 clk. sel_addr=0 after. Next/inc edges during busy are ignored.
//   6. Same-clk write+next edges -> only the write occurs, sel_addr unchanged.
//      rst asserted at 3rd CLR write -> rf_we=0 at once; IDLE after release.

Source files
------------

// File: rtl/regfile_test_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_test_ctrl
//   Button-driven sequencer for the register-file test design. Turns debounced
//   button levels into single-shot operations on the register file. The file
//   has one synchronous read port and one write port, and this block is its
//   only writer:
//     next  : step the selected register index (wraps)
//     write : load the selected register from the switches
//     inc   : read-modify-write the selected register (+1, wrapping)
//     clear : zero every register, lowest address first, then select reg 0
//   Also keeps a registered copy of the selected register for the display.
//
// Ports
//   clk        in   1    system clock, all state updates on posedge
//   rst        in   1    asynchronous, active-high reset
//   btn        in   4    debounced levels: [0] next, [1] write, [2] inc, [3] clear
//   sw         in   DW   switch value, used as write data
//   rf_raddr   out  AW   register file read address (= sel_addr)
//   rf_rdata   in   DW   register file read data, valid 1 clk after rf_raddr
//   rf_we      out  1    register file write enable (registered)
//   rf_waddr   out  AW   register file write address (registered)
//   rf_wdata   out  DW   register file write data (registered)
//   sel_addr   out  AW   currently selected register index
//   disp_data  out  DW   registered copy of rf_rdata for the display
//   busy       out  1    high while an operation is in progress
// -----------------------------------------------------------------------------
module regfile_test_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            btn,
  input  logic [DATA_WIDTH-1:0] sw,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] sel_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  busy
);

  // One extra bit on the clear counter: the MSB marks "all entries written".
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,   // write pulse in flight
    S_RD,   // waiting for read data of the selected register
    S_WB,   // incremented value write pulse in flight
    S_CLR   // walking all addresses with zero writes
  } state_t;

  state_t state, state_nxt;

  logic [3:0]            btn_q;
  logic [3:0]            btn_rise;
  logic [CW-1:0]         clr_cnt, clr_cnt_nxt;
  logic                  clr_done;
  logic [ADDR_WIDTH-1:0] sel_nxt, waddr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt, disp_nxt;
  logic                  we_nxt;

  assign btn_rise = btn & ~btn_q;
  assign clr_done = clr_cnt[ADDR_WIDTH];
  assign busy     = (state != S_IDLE);
  assign rf_raddr = sel_addr;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; clear > write > inc among simultaneous rising edges.
  // Edges outside IDLE are simply ignored, nothing is queued.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if      (btn_rise[3]) state_nxt = S_CLR;
        else if (btn_rise[1]) state_nxt = S_WR;
        else if (btn_rise[2]) state_nxt = S_RD;
      end
      S_WR:  state_nxt = S_IDLE;
      S_RD:  state_nxt = S_WB;
      S_WB:  state_nxt = S_IDLE;
      S_CLR: if (clr_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    sel_nxt     = sel_addr;
    waddr_nxt   = rf_waddr;
    wdata_nxt   = rf_wdata;
    disp_nxt    = disp_data;
    clr_cnt_nxt = clr_cnt;
    we_nxt      = 1'b0;
    unique case (state)
      S_IDLE: begin
        disp_nxt = rf_rdata;
        if (btn_rise[3]) begin
          clr_cnt_nxt = '0;
        end else if (btn_rise[1]) begin
          waddr_nxt = sel_addr;
          wdata_nxt = sw;
          we_nxt    = 1'b1;
        end else if (btn_rise[2]) begin
          // Read data for sel_addr is already valid next cycle: raddr is stable.
        end else if (btn_rise[0]) begin
          sel_nxt = sel_addr + ADDR_WIDTH'(1);
        end
      end
      S_RD: begin
        wdata_nxt = rf_rdata + DATA_WIDTH'(1);
        waddr_nxt = sel_addr;
        we_nxt    = 1'b1;
      end
      S_CLR: begin
        if (clr_done) begin
          sel_nxt = '0;
        end else begin
          we_nxt      = 1'b1;
          waddr_nxt   = clr_cnt[ADDR_WIDTH-1:0];
          wdata_nxt   = '0;
          clr_cnt_nxt = clr_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Output registers. btn_q resets to all-ones so a button already held
  // when reset releases does not register as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q     <= 4'b1111;
      sel_addr  <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      disp_data <= '0;
      clr_cnt   <= '0;
    end else begin
      btn_q     <= btn;
      sel_addr  <= sel_nxt;
      rf_we     <= we_nxt;
      rf_waddr  <= waddr_nxt;
      rf_wdata  <= wdata_nxt;
      disp_data <= disp_nxt;
      clr_cnt   <= clr_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_test_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_test_ctrl
//   Bench for regfile_test_ctrl with a small synchronous-read register file
//   attached. A transaction-level model predicts, per cycle, busy / write
//   pulses / selected index and the register contents; a compare process
//   checks the DUT against it on every falling edge. Directed scenarios add
//   literal expectations on top.
// -----------------------------------------------------------------------------
module tb_regfile_test_ctrl;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int NREG = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    btn = 4'b0100;
  logic [DW-1:0] sw  = '0;
  logic [AW-1:0] rf_raddr, rf_waddr, sel_addr;
  logic [DW-1:0] rf_rdata, rf_wdata, disp_data;
  logic          rf_we, busy;
  logic          rf_init = 1'b1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_test_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .sw        (sw),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .sel_addr  (sel_addr),
    .disp_data (disp_data),
    .busy      (busy)
  );

  // Register file: sync read, read-before-write, contents survive rst.
  logic [DW-1:0] rf_mem [NREG];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] <= DW'(8'h10 + i);
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
    rf_rdata <= rf_mem[rf_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: each accepted operation expands into a list of per-cycle
  // expectations (busy, write pulse); idle cycles are implicit.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic          busy;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          zero_sel;
  } step_t;

  localparam step_t IDLE_STEP = '0;

  step_t         plan [$];
  step_t         m_cur = '0;
  logic [AW-1:0] m_sel = '0;
  logic [DW-1:0] m_mem [NREG];
  logic [3:0]    m_prev = 4'b1111;
  logic [3:0]    m_rise;
  int            m_stab = 0;   // cycles since selection/contents last changed
  logic          m_dirty;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      plan.delete();
      m_cur  = IDLE_STEP;
      m_sel  = '0;
      m_prev = 4'b1111;
      m_stab = 0;
      if (rf_init) for (int i = 0; i < NREG; i++) m_mem[i] = DW'(8'h10 + i);
    end else begin
      m_dirty = 1'b0;
      if (m_cur.we) begin
        m_mem[m_cur.addr] = m_cur.data;
        m_dirty = 1'b1;
      end
      m_rise = btn & ~m_prev;
      m_prev = btn;
      if (!m_cur.busy && plan.size() == 0) begin
        if (m_rise[3]) begin
          plan.push_back('{busy: 1'b1, we: 1'b0, addr: '0, data: '0, zero_sel: 1'b0});
          for (int i = 0; i < NREG; i++)
            plan.push_back('{busy: 1'b1, we: 1'b1, addr: AW'(i), data: '0, zero_sel: 1'b0});
          plan.push_back('{busy: 1'b0, we: 1'b0, addr: '0, data: '0, zero_sel: 1'b1});
        end else if (m_rise[1]) begin
          plan.push_back('{busy: 1'b1, we: 1'b1, addr: m_sel, data: sw, zero_sel: 1'b0});
        end else if (m_rise[2]) begin
          plan.push_back('{busy: 1'b1, we: 1'b0, addr: '0, data: '0, zero_sel: 1'b0});
          plan.push_back('{busy: 1'b1, we: 1'b1, addr: m_sel,
                           data: DW'(m_mem[m_sel] + 1), zero_sel: 1'b0});
        end else if (m_rise[0]) begin
          m_sel   = AW'((m_sel + 1) % NREG);
          m_dirty = 1'b1;
        end
      end
      if (plan.size() != 0) begin
        m_cur = plan.pop_front();
        if (m_cur.zero_sel) begin
          m_sel   = '0;
          m_dirty = 1'b1;
        end
      end else begin
        m_cur = IDLE_STEP;
      end
      if (m_dirty || m_cur.busy) m_stab = 0;
      else if (m_stab < 100)     m_stab++;
    end
  end

  // Compare process
  always @(negedge clk) begin
    check("busy", busy, m_cur.busy);
    check("rf_we", rf_we, m_cur.we);
    check("sel_addr", sel_addr, m_sel);
    if (!m_cur.busy) check("rf_raddr", rf_raddr, m_sel);
    if (m_cur.we) begin
      check("rf_waddr", rf_waddr, m_cur.addr);
      check("rf_wdata", rf_wdata, m_cur.data);
    end
    if (m_stab >= 2) check("disp_data", disp_data, m_mem[m_sel]);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic pulse(input logic [3:0] b);
    @(negedge clk) btn = b;
    @(negedge clk) btn = 4'b0000;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nw, nb;
    // 1: inc held through reset must not fire
    repeat (3) @(negedge clk);
    check("reset_rf_we", rf_we, 0);
    check("reset_busy", busy, 0);
    check("reset_sel", sel_addr, 0);
    rst = 1'b0;
    rf_init = 1'b0;
    nw = 0;
    repeat (4) begin
      @(negedge clk);
      if (rf_we || busy) nw++;
    end
    check("held_btn_no_op", nw, 0);
    btn = 4'b0000;
    idle(1);
    pulse(4'b0100);   // reg0: 0x10 -> 0x11
    check("inc_rd_no_we", rf_we, 0);
    @(negedge clk);
    check("inc_wb_we", rf_we, 1);
    check("inc_wb_data", rf_wdata, 8'h11);
    idle(4);

    // 2: next wraps 7 -> 0
    repeat (9) pulse(4'b0001);
    check("sel_after_9_next", sel_addr, 1);
    pulse(4'b0001);
    idle(3);

    // 3: write A5 to reg 2
    sw = 8'hA5;
    pulse(4'b0010);
    check("wr_we", rf_we, 1);
    check("wr_waddr", rf_waddr, 2);
    check("wr_wdata", rf_wdata, 8'hA5);
    @(negedge clk);
    check("wr_we_1clk", rf_we, 0);
    idle(2);
    check("wr_disp", disp_data, 8'hA5);

    // 4: inc wraps FF -> 00, then 41 -> 42
    sw = 8'hFF;
    pulse(4'b0010);
    idle(3);
    pulse(4'b0100);
    check("incff_rd", rf_we, 0);
    @(negedge clk);
    check("incff_we", rf_we, 1);
    check("incff_addr", rf_waddr, 2);
    check("incff_data", rf_wdata, 8'h00);
    idle(3);
    sw = 8'h41;
    pulse(4'b0010);
    idle(3);
    pulse(4'b0100);
    @(negedge clk);
    check("inc41_data", rf_wdata, 8'h42);
    idle(4);
    check("inc41_disp", disp_data, 8'h42);

    // 5: clear with next/inc presses while busy
    pulse(4'b1000);
    nw = 0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy)  nb++;
      if (rf_we) nw++;
      case (i)
        1: btn = 4'b0001;
        3: btn = 4'b0100;
        2, 4: btn = 4'b0000;
        default: ;
      endcase
      @(negedge clk);
    end
    check("clr_we_pulses", nw, 8);
    check("clr_busy_cycles", nb, 9);
    check("clr_sel", sel_addr, 0);
    idle(2);
    check("clr_disp", disp_data, 8'h00);

    // 6: write+next together -> write only; reset during clear
    pulse(4'b0001);
    sw = 8'h3C;
    pulse(4'b0011);
    check("wn_we", rf_we, 1);
    check("wn_waddr", rf_waddr, 1);
    check("wn_sel", sel_addr, 1);
    idle(4);
    pulse(4'b1000);
    idle(3);
    check("clr3_we", rf_we, 1);
    check("clr3_addr", rf_waddr, 2);
    #2 rst = 1'b1;
    #1;
    check("rst_drops_we", rf_we, 0);
    check("rst_busy", busy, 0);
    idle(2);
    rst = 1'b0;
    idle(3);
    check("post_rst_busy", busy, 0);
    check("post_rst_sel", sel_addr, 0);
    pulse(4'b0100);   // reg0 was cleared before reset: 00 -> 01
    @(negedge clk);
    check("post_rst_inc", rf_wdata, 8'h01);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
